// File: rtl/wb_port_arbiter.sv
// Two-port writeback arbiter with starvation relief for the load port, a
// registered register-file write port, and a pending-destination scoreboard.
module wb_port_arbiter #(
  parameter int RegAddrLen   = 5,
  parameter int RegLen       = 32,
  parameter int RegNum       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid0,
  output logic                  ready0,
  input  logic [RegAddrLen-1:0] addr0,
  input  logic [RegLen-1:0]     data0,
  input  logic                  valid1,
  output logic                  ready1,
  input  logic [RegAddrLen-1:0] addr1,
  input  logic [RegLen-1:0]     data1,
  output logic                  write_enable,
  output logic [RegAddrLen-1:0] write_addr,
  output logic [RegLen-1:0]     write_data,
  input  logic                  issue_valid,
  input  logic [RegAddrLen-1:0] issue_addr,
  input  logic [RegAddrLen-1:0] query_addr1,
  input  logic [RegAddrLen-1:0] query_addr2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  flush
);

  // Handshake: a transfer on port n happens at a posedge where validn && readyn.
  // Ready never depends on ready; only one port can be ready-and-valid at once.

  logic [2:0]            r_starve_cnt;
  logic                  r_we;
  logic [RegAddrLen-1:0] r_waddr;
  logic [RegLen-1:0]     r_wdata;
  logic [RegNum-1:0]     r_busy;

  logic                  w_starved;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_xfer;
  logic [RegAddrLen-1:0] w_xfer_addr;
  logic [RegLen-1:0]     w_xfer_data;
  logic [RegNum-1:0]     w_busy_next;

  assign w_starved   = (r_starve_cnt == 3'(STARVE_LIMIT));
  assign w_ready0    = !rst && !w_starved;
  assign w_ready1    = !rst && (w_starved || !valid0);
  assign w_xfer0     = valid0 && w_ready0;
  assign w_xfer1     = valid1 && w_ready1;
  assign w_xfer      = w_xfer0 || w_xfer1;
  assign w_xfer_addr = w_xfer1 ? addr1 : addr0;
  assign w_xfer_data = w_xfer1 ? data1 : data0;

  assign ready0 = w_ready0;
  assign ready1 = w_ready1;

  // Counter only climbs while the load port waits; any gap or grant resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if (!valid1 || w_xfer1) begin
      r_starve_cnt <= 3'd0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr <= w_xfer_addr;
        r_wdata <= w_xfer_data;
      end
    end
  end

  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;

  // Issue is applied after the clear so a same-edge issue keeps the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (w_xfer && (int'(w_xfer_addr) < RegNum)) begin
      w_busy_next[w_xfer_addr] = 1'b0;
    end
    if (issue_valid && (int'(issue_addr) < RegNum)) begin
      w_busy_next[issue_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy1 = (int'(query_addr1) < RegNum) ? r_busy[query_addr1] : 1'b0;
  assign busy2 = (int'(query_addr2) < RegNum) ? r_busy[query_addr2] : 1'b0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: reference arbitration/scoreboard model, expected
// write queue, directed scenarios followed by randomized traffic.
module tb_wb_port_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREG  = 32;
  localparam int LIMIT = 3;

  logic          clk;
  logic          rst;
  logic          valid0, valid1, ready0, ready1;
  logic [AW-1:0] addr0, addr1, write_addr, issue_addr, query_addr1, query_addr2;
  logic [DW-1:0] data0, data1, write_data;
  logic          write_enable, issue_valid, busy1, busy2, flush;

  wb_port_arbiter #(
    .RegAddrLen(AW), .RegLen(DW), .RegNum(NREG), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .valid0(valid0), .ready0(ready0), .addr0(addr0), .data0(data0),
    .valid1(valid1), .ready1(ready1), .addr1(addr1), .data1(data1),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .query_addr1(query_addr1), .query_addr2(query_addr2),
    .busy1(busy1), .busy2(busy2), .flush(flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               m_wait;
  logic [NREG-1:0]  m_busy;
  logic             m_we;
  logic [AW-1:0]    m_waddr;
  logic [DW-1:0]    m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; issue_addr = '0;
  endtask

  // Called with clk low and inputs already driven; advances one edge.
  task automatic step();
    logic e_r0, e_r1, x0, x1;
    logic [AW+DW-1:0] e;
    #1;
    if (rst) begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
    end else if (m_wait >= LIMIT) begin
      e_r0 = 1'b0;
      e_r1 = 1'b1;
    end else begin
      e_r0 = 1'b1;
      e_r1 = !valid0;
    end
    check("ready0", 64'(ready0), 64'(e_r0));
    check("ready1", 64'(ready1), 64'(e_r1));
    x0 = valid0 && e_r0;
    x1 = valid1 && e_r1;
    if (rst) begin
      m_wait = 0;
      m_busy = '0;
      m_we   = 1'b0;
      exp_q.delete();
    end else begin
      if (x1) exp_q.push_back({addr1, data1});
      else if (x0) exp_q.push_back({addr0, data0});
      m_we = x0 || x1;
      if (valid1 && !x1) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else m_wait = 0;
      if (flush) m_busy = '0;
      else begin
        if (x1) m_busy[addr1] = 1'b0;
        else if (x0) m_busy[addr0] = 1'b0;
        if (issue_valid) m_busy[issue_addr] = 1'b1;
        m_busy[0] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_waddr = '0;
      m_wdata = '0;
    end else if (m_we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_waddr = e[DW +: AW];
      m_wdata = e[DW-1:0];
    end
    check("write_enable", 64'(write_enable), 64'(m_we));
    check("write_addr", 64'(write_addr), 64'(m_waddr));
    check("write_data", 64'(write_data), 64'(m_wdata));
    check("busy1", 64'(busy1), 64'(m_busy[query_addr1]));
    check("busy2", 64'(busy2), 64'(m_busy[query_addr2]));
  endtask

  initial begin
    m_wait = 0; m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    idle_inputs();
    query_addr1 = '0; query_addr2 = '0;

    // reset state
    rst = 1'b1;
    step();
    step();
    check("rst_we", 64'(write_enable), 64'd0);
    rst = 1'b0;

    // issue x5, then port 0 writes x5
    query_addr1 = 5'd5;
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    check("x5_busy_set", 64'(busy1), 64'd1);
    issue_valid = 1'b0;
    valid0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEADBEEF;
    step();
    check("x5_we", 64'(write_enable), 64'd1);
    check("x5_addr", 64'(write_addr), 64'd5);
    check("x5_data", 64'(write_data), 64'hDEADBEEF);
    check("x5_busy_clr", 64'(busy1), 64'd0);
    idle_inputs();
    step();
    check("hold_data", 64'(write_data), 64'hDEADBEEF);

    // both ports contend for 6 cycles: 0,0,0,1,0,0
    valid0 = 1'b1; valid1 = 1'b1;
    addr1 = 5'd20; data1 = 32'h1111_0000;
    for (int i = 1; i <= 6; i++) begin
      addr0 = 5'(i); data0 = 32'hA000_0000 + 32'(i);
      step();
      check("contend_we", 64'(write_enable), 64'd1);
      check("contend_addr", 64'(write_addr), (i == 4) ? 64'd20 : 64'(i));
    end
    idle_inputs();
    step();

    // same-edge issue and transfer to x7: set wins
    query_addr2 = 5'd7;
    issue_valid = 1'b1; issue_addr = 5'd7;
    valid0 = 1'b1; addr0 = 5'd7; data0 = 32'h7777;
    step();
    check("x7_busy", 64'(busy2), 64'd1);
    check("x7_addr", 64'(write_addr), 64'd7);
    idle_inputs();

    // x0 never becomes busy, still written
    query_addr1 = 5'd0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    step();
    issue_valid = 1'b0;
    valid1 = 1'b1; addr1 = 5'd0; data1 = 32'h1;
    step();
    check("x0_busy", 64'(busy1), 64'd0);
    check("x0_we", 64'(write_enable), 64'd1);
    check("x0_addr", 64'(write_addr), 64'd0);
    idle_inputs();

    // flush with issue x9 and an in-flight port 1 write to x3
    issue_valid = 1'b1; issue_addr = 5'd3; step();
    issue_addr = 5'd4; step();
    query_addr1 = 5'd3; query_addr2 = 5'd9;
    flush = 1'b1; issue_addr = 5'd9;
    valid1 = 1'b1; addr1 = 5'd3; data1 = 32'h3333;
    step();
    check("flush_b3", 64'(busy1), 64'd0);
    check("flush_b9", 64'(busy2), 64'd0);
    check("flush_we", 64'(write_enable), 64'd1);
    check("flush_addr", 64'(write_addr), 64'd3);
    idle_inputs();

    // reset on top of a port 0 request
    valid0 = 1'b1; addr0 = 5'd12; data0 = 32'hCAFE;
    rst = 1'b1;
    step();
    check("rst_drop_we", 64'(write_enable), 64'd0);
    check("rst_drop_data", 64'(write_data), 64'd0);
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      valid0      = $urandom_range(0, 1);
      valid1      = $urandom_range(0, 1);
      addr0       = AW'($urandom_range(0, NREG - 1));
      addr1       = AW'($urandom_range(0, NREG - 1));
      data0       = $urandom;
      data1       = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_addr  = AW'($urandom_range(0, NREG - 1));
      query_addr1 = AW'($urandom_range(0, NREG - 1));
      query_addr2 = AW'($urandom_range(0, NREG - 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter RegAddrLen, default 5, register address width.
REQ-002 Parameter RegLen, default 32, register data width.
REQ-003 Parameter RegNum, default 32, number of architectural registers (busy bits).
REQ-004 Parameter STARVE_LIMIT, default 3, consecutive denied cycles before requester 1 gets priority; range 1..7.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 valid0, ready0  input/output  1/1  requester 0 (ALU result) handshake.
REQ-008 addr0, data0  input  RegAddrLen/RegLen  requester 0 destination register and value.
REQ-009 valid1, ready1  input/output  1/1  requester 1 (load result) handshake.
REQ-010 addr1, data1  input  RegAddrLen/RegLen  requester 1 destination register and value.
REQ-011 write_enable, write_addr, write_data  output  1/RegAddrLen/RegLen  registered register-file write port.
REQ-012 issue_valid, issue_addr  input  1/RegAddrLen  decode marks a destination register as pending.
REQ-013 query_addr1, query_addr2  input  RegAddrLen each  operand addresses to check.
REQ-014 busy1, busy2  output  1 each  combinational busy bit of query_addr1/query_addr2.
REQ-015 flush  input  1  branch redirect; clears all pending marks.

Function
REQ-016 A transfer on port n occurs on a posedge where validn && readyn are both 1.
REQ-017 Normal priority: ready0 = 1, ready1 = !valid0; ready depends combinationally on valid and the starvation state only.
REQ-018 Starvation counter: increments, saturating at STARVE_LIMIT, on each cycle with valid1 && !ready1; clears on a requester-1 transfer or any cycle with valid1 = 0.
REQ-019 When counter == STARVE_LIMIT: ready0 = 0, ready1 = 1; the counter clears after the requester-1 transfer.
REQ-020 At most one transfer per cycle; readyn never asserted with the other port's transfer in the same cycle.
REQ-021 Latency 1: a transfer at edge T drives write_enable = 1 with the transferred addr/data during cycle T..T+1; write_enable = 0 in every cycle following an edge without a transfer.
REQ-022 write_addr/write_data hold their last values while write_enable = 0.
REQ-023 Scoreboard: RegNum busy bits; issue_valid at an edge sets busy[issue_addr] unless issue_addr = 0.
REQ-024 A transfer at edge T clears busy[addr] at edge T, so busy drops in the same cycle write_enable rises, relying on the register file's same-cycle write bypass.
REQ-025 Same-edge issue and transfer to the same register: the set wins; the bit stays 1.
REQ-026 busy[0] is constant 0; a transfer to address 0 still produces write_enable = 1 and changes no busy bit.
REQ-027 busy1 = busy[query_addr1], busy2 = busy[query_addr2]; both read the current registered state, with no bypass of this cycle's issue or transfer.
REQ-028 flush at an edge clears all busy bits; an issue_valid on the same edge is ignored.
REQ-029 flush does not affect the handshake, the counter, or the write port; an in-flight transfer still writes.

Reset
REQ-030 rst at an edge forces write_enable = 0, write_addr = 0, write_data = 0, all busy bits = 0, and starvation counter = 0.
REQ-031 During rst: no transfer is recorded, ready0 = ready1 = 0, and issue and flush are ignored.
REQ-032 A transfer aborted by rst mid-operation is dropped; the first cycle after rst deasserts uses normal priority.

Verification
REQ-033 Reset, then issue x5 and query_addr1 = 5 -> busy1 = 1 next cycle; valid0 with addr 5, data 0xDEADBEEF -> next cycle write_enable = 1, write_addr = 5, write_data = 0xDEADBEEF, busy1 = 0.
REQ-034 valid0 and valid1 held 1 for 6 cycles (STARVE_LIMIT = 3) -> port 0 wins cycles 1-3, port 1 wins cycle 4, port 0 wins cycles 5-6; write_enable stays 1 for 6 consecutive cycles.
REQ-035 issue x7 and a transfer to x7 on the same edge -> busy[7] = 1 afterward, and write_enable = 1 for x7 next cycle.
REQ-036 issue x0, then a transfer to x0 with data 0x1 -> busy stays 0, write_enable = 1, write_addr = 0.
REQ-037 busy x3, x4 set, flush together with issue x9 -> all busy bits = 0; a pending valid1 transfer to x3 still writes next cycle.
REQ-038 rst asserted in the same cycle as valid0 = 1 -> no write_enable the following cycle; all outputs 0.
